// File: rtl/rsa_block_feeder.sv
// Packs a byte stream into WIDTH-bit blocks, runs one modular exponentiation per
// block on an external core, and hands each result downstream over valid/ready.
module rsa_block_feeder #(
  parameter int WIDTH           = 16,
  parameter int BYTES_PER_BLOCK = 1,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid_in,
  input  logic                 byte_last_in,
  output logic                 byte_ready_out,
  input  logic [WIDTH-1:0]     modulus_in,
  output logic                 exp_ready_out,
  output logic [WIDTH-1:0]     exp_value_out,
  input  logic                 exp_busy_in,
  input  logic                 exp_valid_in,
  input  logic [2*WIDTH-1:0]   exp_result_in,
  output logic [WIDTH-1:0]     block_out,
  output logic                 block_valid_out,
  output logic                 block_last_out,
  input  logic                 block_ready_in,
  output logic                 busy_out,
  output logic                 err_out
);
  localparam int CW = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_EMIT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] blk_q, blk_d;
  logic             last_q, last_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             exp_ready_q, exp_ready_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_last_q, out_last_d;
  logic             out_vld_q, out_vld_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] byte_sh;

  // Byte k lands just below byte k-1, starting at the top of the packed region.
  assign byte_sh = WIDTH'(byte_in) << (8 * (BYTES_PER_BLOCK - 1 - int'(cnt_q)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    last_d      = last_q;
    tmo_d       = tmo_q;
    exp_ready_d = 1'b0;
    out_d       = out_q;
    out_last_d  = out_last_q;
    out_vld_d   = out_vld_q;
    err_d       = err_q;
    case (state_q)
      S_FILL: if (byte_valid_in) begin
        blk_d = ((cnt_q == '0) ? '0 : blk_q) | byte_sh;
        if (byte_last_in || cnt_q == CW'(BYTES_PER_BLOCK - 1)) begin
          cnt_d   = '0;
          last_d  = byte_last_in;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_START: if (!exp_busy_in) begin
        exp_ready_d = 1'b1;
        tmo_d       = '0;
        state_d     = S_WAIT;
        if (blk_q >= modulus_in) err_d = 1'b1;
      end
      S_WAIT: begin
        // A result arriving on the timeout edge still counts as a result.
        if (exp_valid_in) begin
          out_d      = exp_result_in[WIDTH-1:0];
          out_last_d = last_q;
          out_vld_d  = 1'b1;
          state_d    = S_EMIT;
          if (|exp_result_in[2*WIDTH-1:WIDTH]) err_d = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_FILL;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_EMIT: if (block_ready_in) begin
        out_vld_d = 1'b0;
        state_d   = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      blk_q       <= '0;
      last_q      <= 1'b0;
      tmo_q       <= '0;
      exp_ready_q <= 1'b0;
      out_q       <= '0;
      out_last_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      last_q      <= last_d;
      tmo_q       <= tmo_d;
      exp_ready_q <= exp_ready_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
      out_vld_q   <= out_vld_d;
      err_q       <= err_d;
    end
  end

  assign byte_ready_out  = (state_q == S_FILL) && !rst_in;
  assign busy_out        = (state_q != S_FILL) || (cnt_q != '0);
  assign exp_ready_out   = exp_ready_q;
  assign exp_value_out   = blk_q;
  assign block_out       = out_q;
  assign block_valid_out = out_vld_q;
  assign block_last_out  = out_last_q;
  assign err_out         = err_q;
endmodule

// File: tb/tb_rsa_block_feeder.sv
// Directed bench: a 16-bit feeder against a small modexp core model (e=17),
// plus a 32-bit, 3-byte-per-block instance for packing checks.
module tb_rsa_block_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 16-bit DUT
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0, byte_last = 1'b0, byte_ready;
  logic [15:0] modulus = 16'd3233;
  logic        exp_ready, exp_busy, exp_valid;
  logic [15:0] exp_value, block;
  logic [31:0] exp_result;
  logic        block_valid, block_last, block_ready = 1'b1, busy, err;

  // 32-bit DUT
  logic [7:0]  b2_byte = '0;
  logic        b2_valid = 1'b0, b2_last = 1'b0, b2_ready;
  logic        x2_ready, x2_bvalid, x2_blast, x2_busy, x2_err;
  logic [31:0] x2_value, x2_block;

  // core model state
  logic        model_en = 1'b1, model_hi = 1'b0, hold_busy = 1'b0, inj_valid = 1'b0;
  logic        m_busy = 1'b0, m_valid = 1'b0;
  logic [15:0] m_res = '0;
  int          lat = 3;

  assign exp_busy   = m_busy | hold_busy;
  assign exp_valid  = m_valid | inj_valid;
  assign exp_result = {(model_hi ? 16'h0001 : 16'h0000), m_res};

  rsa_block_feeder #(.WIDTH(16), .BYTES_PER_BLOCK(1), .TIMEOUT_CYCLES(4096)) u16 (
    .clk_in(clk), .rst_in(rst), .byte_in(byte_in), .byte_valid_in(byte_valid),
    .byte_last_in(byte_last), .byte_ready_out(byte_ready), .modulus_in(modulus),
    .exp_ready_out(exp_ready), .exp_value_out(exp_value), .exp_busy_in(exp_busy),
    .exp_valid_in(exp_valid), .exp_result_in(exp_result), .block_out(block),
    .block_valid_out(block_valid), .block_last_out(block_last),
    .block_ready_in(block_ready), .busy_out(busy), .err_out(err));

  rsa_block_feeder #(.WIDTH(32), .BYTES_PER_BLOCK(3), .TIMEOUT_CYCLES(4096)) u32 (
    .clk_in(clk), .rst_in(rst), .byte_in(b2_byte), .byte_valid_in(b2_valid),
    .byte_last_in(b2_last), .byte_ready_out(b2_ready), .modulus_in(32'hFFFF_FFFF),
    .exp_ready_out(x2_ready), .exp_value_out(x2_value), .exp_busy_in(1'b0),
    .exp_valid_in(1'b0), .exp_result_in(64'h0), .block_out(x2_block),
    .block_valid_out(x2_bvalid), .block_last_out(x2_blast),
    .block_ready_in(1'b1), .busy_out(x2_busy), .err_out(x2_err));

  int n_chk = 0, n_fail = 0;
  int pulse_cnt = 0, pulse32_cnt = 0, vld_cnt = 0;

  always @(posedge clk) begin
    if (exp_ready)   pulse_cnt   <= pulse_cnt + 1;
    if (x2_ready)    pulse32_cnt <= pulse32_cnt + 1;
    if (block_valid) vld_cnt     <= vld_cnt + 1;
  end

  function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] m);
    logic [63:0] r, x;
    logic [4:0]  e;
    r = 64'd1; x = {48'd0, b} % {48'd0, m}; e = 5'd17;
    for (int i = 0; i < 5; i++) begin
      if (e[i]) r = (r * x) % {48'd0, m};
      x = (x * x) % {48'd0, m};
    end
    return r[15:0];
  endfunction

  // Core model: busy for lat cycles after each start pulse, then one valid pulse.
  initial forever begin
    @(negedge clk);
    if (exp_ready && model_en) begin
      m_busy = 1'b1;
      m_res  = modexp(exp_value, modulus);
      repeat (lat - 1) @(negedge clk);
      m_valid = 1'b1;
      @(negedge clk);
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    byte_in = b; byte_valid = 1'b1; byte_last = l;
    step();
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic wait_vld(input int bound);
    for (int i = 0; i < bound; i++) begin
      step();
      if (block_valid) break;
    end
    chk("block_valid_seen", block_valid, 1'b1);
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_byte_ready"}, byte_ready, 1'b0);
    chk({tag, "_exp_ready"}, exp_ready, 1'b0);
    chk({tag, "_exp_value"}, exp_value, 16'h0);
    chk({tag, "_block_valid"}, block_valid, 1'b0);
    chk({tag, "_block_last"}, block_last, 1'b0);
    chk({tag, "_block"}, block, 16'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_x2_value"}, x2_value, 32'h0);
    step();
    rst = 1'b0;
    step();
  endtask

  int p0, v0;

  initial begin
    step();
    reset_check("reset");

    // WIDTH=32, 3 bytes/block: short message packs MSB-first, low byte zero
    p0 = pulse32_cnt;
    b2_byte = 8'h12; b2_valid = 1'b1; b2_last = 1'b0;
    step();
    chk("t2_partial_value", x2_value, 32'h0012_0000);
    chk("t2_partial_busy", x2_busy, 1'b1);
    chk("t2_still_ready", b2_ready, 1'b1);
    b2_byte = 8'h34; b2_last = 1'b1;
    step();
    b2_valid = 1'b0; b2_last = 1'b0;
    chk("t2_value", x2_value, 32'h0012_3400);
    chk("t2_ready_low", b2_ready, 1'b0);
    step();
    chk("t2_start", x2_ready, 1'b1);
    repeat (3) step();
    chk("t2_one_pulse", pulse32_cnt - p0, 1);

    // Basic block: 0x41^17 mod 3233 = 2790
    p0 = pulse_cnt;
    send(8'h41, 1'b1);
    chk("t1_value", exp_value, 16'h0041);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready_low", byte_ready, 1'b0);
    chk("t1_no_start_yet", exp_ready, 1'b0);
    step();
    chk("t1_start", exp_ready, 1'b1);
    wait_vld(50);
    chk("t1_block", block, 16'd2790);
    chk("t1_last", block_last, 1'b1);
    chk("t1_err", err, 1'b0);
    chk("t1_one_pulse", pulse_cnt - p0, 1);
    step();
    chk("t1_vld_drop", block_valid, 1'b0);
    chk("t1_idle", busy, 1'b0);
    chk("t1_fill", byte_ready, 1'b1);

    // Core busy delays start; downstream back-pressure holds the block (2^17 mod 3233 = 1752)
    hold_busy = 1'b1; block_ready = 1'b0;
    p0 = pulse_cnt;
    send(8'h02, 1'b0);
    repeat (3) step();
    chk("t3_no_start_busy", pulse_cnt - p0, 0);
    chk("t3_no_start_now", exp_ready, 1'b0);
    hold_busy = 1'b0;
    step();
    chk("t3_start", exp_ready, 1'b1);
    wait_vld(50);
    byte_in = 8'hAA; byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_vld", block_valid, 1'b1);
      chk("t3_hold_block", block, 16'd1752);
      chk("t3_hold_last", block_last, 1'b0);
      chk("t3_hold_bp", byte_ready, 1'b0);
      if (i < 9) step();
    end
    byte_valid = 1'b0; block_ready = 1'b1;
    step();
    chk("t3_accepted", block_valid, 1'b0);
    chk("t3_fill", byte_ready, 1'b1);
    chk("t3_no_stray_byte", busy, 1'b0);

    // Block >= modulus: error raised at start, block still emitted
    modulus = 16'd200;
    send(8'hC8, 1'b1);
    step();
    chk("t4_start", exp_ready, 1'b1);
    chk("t4_err", err, 1'b1);
    wait_vld(50);
    chk("t4_block", block, 16'd0);
    step();
    chk("t4_err_sticky", err, 1'b1);
    modulus = 16'd3233;

    reset_check("reset2");

    // Timeout: no result ever arrives
    model_en = 1'b0;
    v0 = vld_cnt;
    send(8'h05, 1'b1);
    step();
    chk("t5_start", exp_ready, 1'b1);
    repeat (4095) step();
    chk("t5_still_wait", busy, 1'b1);
    chk("t5_no_err_yet", err, 1'b0);
    step();
    chk("t5_timeout_err", err, 1'b1);
    chk("t5_back_fill", busy, 1'b0);
    chk("t5_byte_ready", byte_ready, 1'b1);
    inj_valid = 1'b1;
    step();
    inj_valid = 1'b0;
    step();
    chk("t5_late_ignored", busy, 1'b0);
    chk("t5_never_valid", vld_cnt - v0, 0);
    model_en = 1'b1;

    // Reset during WAIT; the stale core result must not surface
    lat = 20;
    send(8'h07, 1'b1);
    step();
    chk("t6_start", exp_ready, 1'b1);
    repeat (3) step();
    v0 = vld_cnt;
    reset_check("t6_reset");
    repeat (25) step();
    chk("t6_stale_ignored", vld_cnt - v0, 0);
    chk("t6_idle", busy, 1'b0);
    send(8'h41, 1'b1);
    chk("t6_fresh_value", exp_value, 16'h0041);
    step();
    chk("t6_fresh_start", exp_ready, 1'b1);
    wait_vld(60);
    chk("t6_fresh_block", block, 16'd2790);
    chk("t6_err_clear", err, 1'b0);
    step();

    // Nonzero upper half of the core result flags an error
    lat = 3; model_hi = 1'b1;
    send(8'h41, 1'b1);
    step();
    wait_vld(50);
    chk("hi_half_err", err, 1'b1);
    model_hi = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
